// File: rtl/skew_buffer_pkg.sv
// Shared types and helpers for the AXI-Stream skew/deskew buffer.
// Optional feature macro used by the top level: SKEW_BUFFER_PERF_EN.
package skew_buffer_pkg;

  // Delay profile across the lanes
  typedef enum logic {
    SKEW   = 1'b0,
    DESKEW = 1'b1
  } skew_mode_e;

  // Packet-level control state of the buffer
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } skew_state_e;

  // Number of delay registers in front of the shared output register for lane c
  function automatic int lane_delay(skew_mode_e mode, int lanes, int c);
    if (mode == DESKEW) begin
      return lanes - 1 - c;
    end
    return c;
  endfunction

endpackage

// File: rtl/skew_buffer_axis_delay.sv
// Stallable shift-register delay line; one instance per lane.
// DEPTH=0 collapses to a plain wire so lane 0 (or the last lane in deskew
// mode) only sees the shared output register.
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = clk_i ^ rst_i ^ shift_en;
    assign delayed     = data;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one position per enabled cycle; hold otherwise so stalls freeze the lane
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= '0;
        end
      end else if (shift_en) begin
        stage_q[0] <= data;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign delayed = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/skew_buffer_axis.sv
// Packet-aware triangular skew/deskew buffer with AXI-Stream handshakes.
// Every packet is followed by LANES-1 injected zero beats so the triangle
// drains fully before the next packet is accepted.
// Optional: define SKEW_BUFFER_PERF_EN to add the perf_stall_o counter.
module skew_buffer_axis
  import skew_buffer_pkg::*;
#(
  parameter int         WIDTH = 8,
  parameter int         LANES = 4,
  parameter skew_mode_e MODE  = SKEW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [LANES*WIDTH-1:0] s_data_i,
  input  logic                   s_last_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [LANES*WIDTH-1:0] m_data_o,
  output logic                   m_last_o
`ifdef SKEW_BUFFER_PERF_EN
  ,
  output logic [31:0]            perf_stall_o
`endif
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(LANES - 1);

  skew_state_e            state_q, state_d;
  logic [CNT_W-1:0]       flush_cnt_q;
  logic                   advance;
  logic                   accept;
  logic                   inject;
  logic                   shift_en;
  logic [LANES*WIDTH-1:0] stage_in;
  logic [LANES*WIDTH-1:0] lane_out;
  logic                   last_in;
  logic                   last_out;

  assign advance   = !m_valid_o | m_ready_i;
  assign s_ready_o = advance & (state_q != FLUSH);
  assign accept    = s_valid_i & s_ready_o;
  assign inject    = advance & (state_q == FLUSH);
  assign shift_en  = accept | inject;
  assign stage_in  = accept ? s_data_i : '0;
  assign last_in   = accept & s_last_i;

  for (genvar c = 0; c < LANES; c++) begin : g_lane
    skew_delay_line #(
      .WIDTH (WIDTH),
      .DEPTH (lane_delay(MODE, LANES, c))
    ) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .shift_en (shift_en),
      .data     (stage_in[c*WIDTH +: WIDTH]),
      .delayed  (lane_out[c*WIDTH +: WIDTH])
    );
  end

  // The packet's last flag travels as far as the most delayed lane
  skew_delay_line #(
    .WIDTH (1),
    .DEPTH (LANES - 1)
  ) u_last (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .shift_en (shift_en),
    .data     (last_in),
    .delayed  (last_out)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter flush on the last accepted beat, leave when the zeros are all injected
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          if (s_last_i) begin
            state_d = (LANES > 1) ? FLUSH : IDLE;
          end else begin
            state_d = STREAM;
          end
        end
      end
      FLUSH: begin
        if (advance && (flush_cnt_q <= CNT_W'(1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Count the zero beats still owed to drain the triangle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flush_cnt_q <= '0;
    end else if (last_in && (LANES > 1)) begin
      flush_cnt_q <= FLUSH_LOAD;
    end else if (inject && (flush_cnt_q != '0)) begin
      flush_cnt_q <= flush_cnt_q - 1'b1;
    end
  end

  // Shared output register; data holds on bubbles, valid drops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      m_data_o  <= '0;
    end else if (advance) begin
      m_valid_o <= shift_en;
      m_last_o  <= shift_en & last_out;
      if (shift_en) begin
        m_data_o <= lane_out;
      end
    end
  end

`ifdef SKEW_BUFFER_PERF_EN
  // Saturating count of cycles where a valid output is held by the sink
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_o <= '0;
    end else if (m_valid_o && !m_ready_i && (perf_stall_o != 32'hFFFF_FFFF)) begin
      perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_skew_buffer_axis.sv
// Directed bench for skew_buffer_axis: a SKEW and a DESKEW instance share
// the same stimulus. Perf-counter checks compile in with SKEW_BUFFER_PERF_EN.
module tb_skew_buffer_axis;
  import skew_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b1;

  logic        sk_s_ready, sk_m_valid, sk_m_last;
  logic [31:0] sk_m_data;
  logic        dk_s_ready, dk_m_valid, dk_m_last;
  logic [31:0] dk_m_data;
`ifdef SKEW_BUFFER_PERF_EN
  logic [31:0] sk_perf, dk_perf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  skew_buffer_axis #(.WIDTH(8), .LANES(4), .MODE(SKEW)) u_skew (
    .clk_i     (clk),
    .rst_i     (rst),
    .s_valid_i (s_valid),
    .s_ready_o (sk_s_ready),
    .s_data_i  (s_data),
    .s_last_i  (s_last),
    .m_valid_o (sk_m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (sk_m_data),
    .m_last_o  (sk_m_last)
`ifdef SKEW_BUFFER_PERF_EN
    ,
    .perf_stall_o (sk_perf)
`endif
  );

  skew_buffer_axis #(.WIDTH(8), .LANES(4), .MODE(DESKEW)) u_deskew (
    .clk_i     (clk),
    .rst_i     (rst),
    .s_valid_i (s_valid),
    .s_ready_o (dk_s_ready),
    .s_data_i  (s_data),
    .s_last_i  (s_last),
    .m_valid_o (dk_m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (dk_m_data),
    .m_last_o  (dk_m_last)
`ifdef SKEW_BUFFER_PERF_EN
    ,
    .perf_stall_o (dk_perf)
`endif
  );

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (sk_m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid got=%0b exp=0", sk_m_valid); end
    checks++; if (sk_m_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_m_data got=%h exp=00000000", sk_m_data); end
    checks++; if (sk_m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_last got=%0b exp=0", sk_m_last); end
    checks++; if (sk_s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_ready got=%0b exp=1", sk_s_ready); end
    checks++; if (dk_m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dk_m_valid got=%0b exp=0", dk_m_valid); end
`ifdef SKEW_BUFFER_PERF_EN
    checks++; if (sk_perf !== 32'd0) begin errors++; $display("[TB] FAIL reset_perf got=%0d exp=0", sk_perf); end
`endif
  endtask

  task automatic test_skew_single();
    logic [31:0] exp_d [4];
    exp_d = '{32'h00000001, 32'h00000200, 32'h00030000, 32'h04000000};
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'h04030201; s_last = 1'b1;
    #1;
    checks++; if (sk_s_ready !== 1'b1) begin errors++; $display("[TB] FAIL skew_in_ready got=%0b exp=1", sk_s_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin s_valid = 1'b0; s_data = '0; s_last = 1'b0; end
      #1;
      checks++; if (sk_m_valid !== 1'b1) begin errors++; $display("[TB] FAIL skew_valid[%0d] got=%0b exp=1", i, sk_m_valid); end
      checks++; if (sk_m_data !== exp_d[i]) begin errors++; $display("[TB] FAIL skew_data[%0d] got=%h exp=%h", i, sk_m_data, exp_d[i]); end
      checks++; if (sk_m_last !== (i == 3)) begin errors++; $display("[TB] FAIL skew_last[%0d] got=%0b exp=%0b", i, sk_m_last, (i == 3)); end
      checks++; if (sk_s_ready !== (i == 3)) begin errors++; $display("[TB] FAIL skew_flush_ready[%0d] got=%0b exp=%0b", i, sk_s_ready, (i == 3)); end
    end
    @(negedge clk); #1;
    checks++; if (sk_m_valid !== 1'b0) begin errors++; $display("[TB] FAIL skew_drained got=%0b exp=0", sk_m_valid); end
  endtask

  task automatic test_deskew_single();
    logic [31:0] exp_d [4];
    exp_d = '{32'h04000000, 32'h00030000, 32'h00000200, 32'h00000001};
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'h04030201; s_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin s_valid = 1'b0; s_data = '0; s_last = 1'b0; end
      #1;
      checks++; if (dk_m_valid !== 1'b1) begin errors++; $display("[TB] FAIL deskew_valid[%0d] got=%0b exp=1", i, dk_m_valid); end
      checks++; if (dk_m_data !== exp_d[i]) begin errors++; $display("[TB] FAIL deskew_data[%0d] got=%h exp=%h", i, dk_m_data, exp_d[i]); end
      checks++; if (dk_m_last !== (i == 3)) begin errors++; $display("[TB] FAIL deskew_last[%0d] got=%0b exp=%0b", i, dk_m_last, (i == 3)); end
    end
    @(negedge clk); #1;
    checks++; if (dk_m_valid !== 1'b0) begin errors++; $display("[TB] FAIL deskew_drained got=%0b exp=0", dk_m_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [6];
    exp_d = '{32'h00000001, 32'h00000205, 32'h00030609,
              32'h04070A00, 32'h080B0000, 32'h0C000000};
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'h04030201; s_last = 1'b0; m_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (sk_m_data !== exp_d[0] || sk_m_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_y0 got=%h/%0b exp=%h/1", sk_m_data, sk_m_valid, exp_d[0]); end
    s_data = 32'h08070605;
    @(negedge clk);
    s_data = 32'h0C0B0A09; s_last = 1'b1; m_ready = 1'b0;
    #1;
    checks++; if (sk_m_data !== exp_d[1] || sk_m_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_y1 got=%h/%0b exp=%h/1", sk_m_data, sk_m_valid, exp_d[1]); end
    checks++; if (sk_s_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_stall got=%0b exp=0", sk_s_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) m_ready = 1'b1;
      #1;
      checks++; if (sk_m_data !== exp_d[1] || sk_m_valid !== 1'b1 || sk_m_last !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold[%0d] got=%h/%0b/%0b exp=%h/1/0", i, sk_m_data, sk_m_valid, sk_m_last, exp_d[1]); end
      checks++; if (sk_s_ready !== (i == 2)) begin errors++; $display("[TB] FAIL bp_hold_ready[%0d] got=%0b exp=%0b", i, sk_s_ready, (i == 2)); end
    end
    for (int i = 2; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) begin s_valid = 1'b0; s_data = '0; s_last = 1'b0; end
      #1;
      checks++; if (sk_m_data !== exp_d[i] || sk_m_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_y%0d got=%h/%0b exp=%h/1", i, sk_m_data, sk_m_valid, exp_d[i]); end
      checks++; if (sk_m_last !== (i == 5)) begin errors++; $display("[TB] FAIL bp_last[%0d] got=%0b exp=%0b", i, sk_m_last, (i == 5)); end
    end
    @(negedge clk); #1;
    checks++; if (sk_m_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained got=%0b exp=0", sk_m_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] drv_d [11];
    logic        drv_v [11];
    logic        drv_l [11];
    logic        exp_r [11];
    logic        exp_v [11];
    logic        exp_l [11];
    logic [31:0] exp_d [11];
    drv_d = '{32'h04030201, 32'h08070605, 32'h14131211, 32'h14131211, 32'h14131211,
              32'h14131211, 32'h18171615, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    drv_v = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    drv_l = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    exp_r = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1};
    exp_v = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    exp_l = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    exp_d = '{32'h0, 32'h00000001, 32'h00000205, 32'h00030600, 32'h04070000, 32'h08000000,
              32'h00000011, 32'h00001215, 32'h00131600, 32'h14170000, 32'h18000000};
    m_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      s_valid = drv_v[i]; s_data = drv_d[i]; s_last = drv_l[i];
      #1;
      checks++; if (sk_s_ready !== exp_r[i]) begin errors++; $display("[TB] FAIL b2b_ready[%0d] got=%0b exp=%0b", i, sk_s_ready, exp_r[i]); end
      checks++; if (sk_m_valid !== exp_v[i]) begin errors++; $display("[TB] FAIL b2b_valid[%0d] got=%0b exp=%0b", i, sk_m_valid, exp_v[i]); end
      if (exp_v[i]) begin
        checks++; if (sk_m_data !== exp_d[i]) begin errors++; $display("[TB] FAIL b2b_data[%0d] got=%h exp=%h", i, sk_m_data, exp_d[i]); end
        checks++; if (sk_m_last !== exp_l[i]) begin errors++; $display("[TB] FAIL b2b_last[%0d] got=%0b exp=%0b", i, sk_m_last, exp_l[i]); end
      end
    end
    s_data = '0;
    @(negedge clk); #1;
    checks++; if (sk_m_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained got=%0b exp=0", sk_m_valid); end
  endtask

  task automatic test_reset_flush();
    logic [31:0] exp_d [4];
    exp_d = '{32'h00000005, 32'h00000600, 32'h00070000, 32'h08000000};
    m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'h04030201; s_last = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    #1;
    checks++; if (sk_s_ready !== 1'b0 || sk_m_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstf_in_flush ready=%0b valid=%0b exp ready=0 valid=1", sk_s_ready, sk_m_valid); end
    rst = 1'b1;
    #1;
    checks++; if (sk_m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstf_async_valid got=%0b exp=0", sk_m_valid); end
    checks++; if (sk_m_data !== 32'h0 || sk_m_last !== 1'b0) begin errors++; $display("[TB] FAIL rstf_async_data got=%h/%0b exp=00000000/0", sk_m_data, sk_m_last); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (sk_s_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstf_ready got=%0b exp=1", sk_s_ready); end
`ifdef SKEW_BUFFER_PERF_EN
    checks++; if (sk_perf !== 32'd0) begin errors++; $display("[TB] FAIL rstf_perf got=%0d exp=0", sk_perf); end
`endif
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'h08070605; s_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin s_valid = 1'b0; s_data = '0; s_last = 1'b0; end
      #1;
      checks++; if (sk_m_data !== exp_d[i] || sk_m_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstf_y%0d got=%h/%0b exp=%h/1", i, sk_m_data, sk_m_valid, exp_d[i]); end
      checks++; if (sk_m_last !== (i == 3)) begin errors++; $display("[TB] FAIL rstf_last[%0d] got=%0b exp=%0b", i, sk_m_last, (i == 3)); end
    end
    @(negedge clk); #1;
    checks++; if (sk_m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstf_drained got=%0b exp=0", sk_m_valid); end
  endtask

`ifdef SKEW_BUFFER_PERF_EN
  task automatic test_perf();
    m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'h04030201; s_last = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    checks++; if (sk_perf !== 32'd7) begin errors++; $display("[TB] FAIL perf_count got=%0d exp=7", sk_perf); end
    checks++; if (sk_m_data !== 32'h00000001) begin errors++; $display("[TB] FAIL perf_hold got=%h exp=00000001", sk_m_data); end
    m_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (sk_perf !== 32'd7 || sk_m_valid !== 1'b0) begin errors++; $display("[TB] FAIL perf_after got=%0d/%0b exp=7/0", sk_perf, sk_m_valid); end
  endtask
`endif

  initial begin
    $display("[TB] starting skew_buffer_axis bench");
    test_reset();
    test_skew_single();
    test_deskew_single();
    test_backpressure();
    test_back_to_back();
    test_reset_flush();
`ifdef SKEW_BUFFER_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/skew_buffer_axis.md
# skew_buffer_axis

AXI-Stream triangular skew/deskew buffer feeding and draining the systolic array edges. It has a `LANES`-wide beat interface. Lane `c` is delayed by a mode-dependent number of beats. Each packet is followed by an automatic zero-fill flush so the delay triangle drains completely, and `valid`/`ready` backpressure is honoured end to end. It supersedes the free-running enable-gated triangle with a packet-aware, stallable, bidirectional version.

## Interface
Parameters:
- `WIDTH`, 8, bits per lane element
- `LANES`, 4, lane count; must be ≥1
- `MODE`, `SKEW`, delay profile from the package enum:
  - `SKEW`: lane `c` has delay `d(c)=c`.
  - `DESKEW`: lane `c` has delay `d(c)=LANES-1-c`.

Ports:
- `clk_i` in 1 — single clock; all logic on its rising edge.
- `rst_i` in 1 — reset, asynchronous and active-high.
- `s_valid_i` in 1 — input beat valid.
- `s_ready_o` out 1 — input beat accepted when `s_valid_i & s_ready_o`.
- `s_data_i` in `LANES*WIDTH` — packed lanes; lane `c` is at bits `[c*WIDTH +: WIDTH]`.
- `s_last_i` in 1 — final beat of packet.
- `m_valid_o` out 1 — output beat valid.
- `m_ready_i` in 1 — downstream ready.
- `m_data_o` out `LANES*WIDTH` — skewed lanes, same packing as `s_data_i`.
- `m_last_o` out 1 — final beat of output packet.
- `perf_stall_o` out 32 — present only with `SKEW_BUFFER_PERF_EN`.

## Operation
- Input packet beats are `x[0..N-1]`, where `N≥1` and `s_last_i` is set on `x[N-1]`.
- Output packet beats are `y[0..N+LANES-2]`:
  - `y[k]` lane `c` = `x[k-d(c)]` lane `c` when `0 ≤ k-d(c) < N`, else 0.
  - `m_last_o` is set only on `y[N+LANES-2]`.
- `advance = !m_valid_o | m_ready_i`. When `advance` is high, every delay stage and the output register shift by one beat; when low, all state holds.
- State machine: `IDLE`, `STREAM`, `FLUSH`.
  - `IDLE → STREAM` on an accepted non-last beat.
  - `IDLE`/`STREAM → FLUSH` on an accepted last beat, provided `LANES>1`.
  - `IDLE`/`STREAM → IDLE` on an accepted last beat when `LANES==1`.
  - `FLUSH → IDLE` when the flush counter reaches 0 on an `advance` cycle.
- Flush counter:
  - Loaded with `LANES-1` on the accepted last beat.
  - Each `advance` cycle in `FLUSH` injects an all-zero beat and decrements the counter.
  - The beat injected at count 1 carries `last` to the output.
- Input ready: `s_ready_o = advance & (state != FLUSH)`. No input is accepted during flush.
- In `STREAM`, an `advance` cycle with no input beat (source bubble) shifts nothing. Bubbles compress out and never appear on `m_*`.
- Lanes carry data unchanged; no arithmetic. The stage count per lane is `d(c)` registers plus one shared output register.
- `m_valid_o`:
  - Set when a beat (input or flush) enters the output register on an `advance` cycle.
  - Cleared on an `advance` cycle with nothing entering.
- Data stages are not cleared between packets. The flush zero-fill guarantees zeros in untouched positions of the next packet.

## Timing
- Latency: input beat accepted in cycle `t` → `y[0]` is presented with `m_valid_o=1` in cycle `t+1`.
- Throughput: one beat per cycle with no backpressure. A packet of `N` beats occupies `N+LANES-1` output cycles; `s_ready_o` is low for `LANES-1` cycles after each last beat.
- Under `m_ready_i=0` with `m_valid_o=1`, `m_data_o` and `m_last_o` are stable and `s_ready_o=0`.
- Reset values:
  - `m_valid_o=0`, `m_data_o=0`, `m_last_o=0`, all stages 0.
  - State `IDLE`, flush counter 0, `perf_stall_o=0`.
  - `s_ready_o=1` in the first cycle after deassert.
- Reset mid-packet or mid-flush: all state clears asynchronously. The partial output packet is abandoned without `m_last_o`. The next packet starts clean.
- Simultaneous accepted last beat and output stall cannot occur, because acceptance implies `advance`.

## Configuration
- `SKEW_BUFFER_PERF_EN` defined:
  - Adds `perf_stall_o`, counting cycles with `m_valid_o & !m_ready_i`.
  - Saturates at `2^32-1`.
  - Cleared only by reset.
- `SKEW_BUFFER_PERF_EN` undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- `skew_buffer_pkg`:
  - `skew_mode_e` (`SKEW`, `DESKEW`).
  - `skew_state_e` (`IDLE`, `STREAM`, `FLUSH`).
  - Function `lane_delay(mode, lanes, c)` returning `d(c)`.
- Sub-module `skew_delay_line`:
  - Parameters `WIDTH`, `DEPTH`; shift enable; async active-high reset.
  - `DEPTH=0` is a wire.
  - One instance per lane, with `DEPTH=lane_delay(...)`.
- The top level holds the FSM, flush counter, output register, `last` delay (depth `LANES-1`) and the optional perf counter.

## Test plan
All scenarios use `LANES=4`, `WIDTH=8`; lanes are listed as `[lane0, lane1, lane2, lane3]`.
- **`SKEW`, single beat:** `[1,2,3,4]` with last → outputs `[1,0,0,0]`, `[0,2,0,0]`, `[0,0,3,0]`, `[0,0,0,4]`, with `m_last_o` only on the fourth.
- **`DESKEW`, same input** → outputs `[0,0,0,4]`, `[0,0,3,0]`, `[0,2,0,0]`, `[1,0,0,0]`, with `m_last_o` on the fourth.
- **Backpressure:** `SKEW`, 3-beat packet, `m_ready_i` low 3 cycles after `y[1]` → `y[1]` held stable, `s_ready_o=0` throughout, 6 correct beats total.
- **Back-to-back packets:** `s_valid_i` held high across two packets → `s_ready_o=0` for exactly 3 cycles after each last; no lane bleeds between packets.
- **Reset:** `rst_i` pulsed during `FLUSH` → `m_valid_o=0` immediately. A subsequent `[5,6,7,8]` packet yields a clean 4-beat diagonal.
- **Perf counter:** with `SKEW_BUFFER_PERF_EN`, 7 stalled valid cycles → `perf_stall_o=7`.
